// File: rtl/timer_cnt_core_if.sv
// Register-block <-> counting-engine bundle: TDR/TCR/TSR controls in, TCNT/flags/tick out.
interface timer_cnt_core_if #(
    parameter int CNT_WIDTH = 8
);
    logic [CNT_WIDTH-1:0] tdr_data;
    logic                 load;
    logic                 cnt_en;
    logic                 cnt_dwn;
    logic [1:0]           clk_sel;
    logic                 ovf_clr;
    logic                 udf_clr;
    logic [CNT_WIDTH-1:0] tcnt;
    logic                 ovf_flag;
    logic                 udf_flag;
    logic                 tick;

    modport master (
        output tdr_data, load, cnt_en, cnt_dwn, clk_sel, ovf_clr, udf_clr,
        input  tcnt, ovf_flag, udf_flag, tick
    );

    modport slave (
        input  tdr_data, load, cnt_en, cnt_dwn, clk_sel, ovf_clr, udf_clr,
        output tcnt, ovf_flag, udf_flag, tick
    );
endinterface

// File: rtl/timer_cnt_core.sv
// Timer counting engine: PCLK prescaler, run/idle FSM, up/down counter and sticky wrap flags.
module timer_cnt_core #(
    parameter int CNT_WIDTH = 8,
    parameter int DIV_WIDTH = 4
) (
    input  logic             pclk,
    input  logic             preset,
    timer_cnt_core_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic                   run;
    logic [DIV_WIDTH-1:0]   div_cnt_reg;
    logic [DIV_WIDTH-1:0]   div_cnt_next;
    logic [DIV_WIDTH-1:0]   sel_mask;
    logic                   tick;
    logic                   step;
    logic                   ovf_set;
    logic                   udf_set;
    logic [CNT_WIDTH-1:0]   tcnt_reg;
    logic [CNT_WIDTH-1:0]   tcnt_next;
    logic                   ovf_reg;
    logic                   ovf_next;
    logic                   udf_reg;
    logic                   udf_next;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.cnt_en)  state_next = RUN;
            RUN:     if (!bus.cnt_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        run = (state_reg == RUN);
    end

    // Low (clk_sel+1) bits of div_cnt participate in the tick decode.
    generate
        for (genvar gi = 0; gi < DIV_WIDTH; gi++) begin : g_sel_mask
            assign sel_mask[gi] = (gi <= int'(bus.clk_sel));
        end
    endgenerate

    assign tick = run && (&(div_cnt_reg | ~sel_mask));
    assign step = tick && !bus.load;

    // div_cnt only advances while staying in RUN, so entry and load both restart a full period.
    always_comb begin
        div_cnt_next = '0;
        if (!bus.load && run && bus.cnt_en) begin
            div_cnt_next = div_cnt_reg + DIV_WIDTH'(1);
        end
    end

    always_comb begin
        tcnt_next = tcnt_reg;
        ovf_set   = 1'b0;
        udf_set   = 1'b0;
        if (bus.load) begin
            tcnt_next = bus.tdr_data;
        end else if (step) begin
            if (bus.cnt_dwn) begin
                tcnt_next = tcnt_reg - CNT_WIDTH'(1);
                udf_set   = (tcnt_reg == '0);
            end else begin
                tcnt_next = tcnt_reg + CNT_WIDTH'(1);
                ovf_set   = (tcnt_reg == '1);
            end
        end
    end

    // A coincident set outranks the clear strobe.
    always_comb begin
        ovf_next = ovf_set | (ovf_reg & ~bus.ovf_clr);
        udf_next = udf_set | (udf_reg & ~bus.udf_clr);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            div_cnt_reg <= '0;
            tcnt_reg    <= '0;
            ovf_reg     <= 1'b0;
            udf_reg     <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            tcnt_reg    <= tcnt_next;
            ovf_reg     <= ovf_next;
            udf_reg     <= udf_next;
        end
    end

    assign bus.tcnt     = tcnt_reg;
    assign bus.ovf_flag = ovf_reg;
    assign bus.udf_flag = udf_reg;
    assign bus.tick     = tick;
endmodule

// File: tb/tb_timer_cnt_core.sv
// Directed plus randomized bench for timer_cnt_core against a cycle-count reference model.
module tb_timer_cnt_core;
    logic pclk   = 1'b0;
    logic preset = 1'b1;

    always #5 pclk = ~pclk;

    timer_cnt_core_if #(.CNT_WIDTH(8)) bus();

    timer_cnt_core #(.CNT_WIDTH(8), .DIV_WIDTH(4)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: running flag, pclks elapsed in the current period, count value, flags.
    bit m_run;
    int m_el;
    int m_cnt;
    bit m_ovf;
    bit m_udf;

    function automatic bit m_tick();
        int period;
        period = 2 << bus.clk_sel;
        return m_run && (((m_el + 1) % period) == 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".tcnt"}, 32'(bus.tcnt),     32'(m_cnt));
        check({ctx, ".ovf"},  32'(bus.ovf_flag), 32'(m_ovf));
        check({ctx, ".udf"},  32'(bus.udf_flag), 32'(m_udf));
        check({ctx, ".tick"}, 32'(bus.tick),     32'(m_tick()));
    endtask

    task automatic model_reset();
        m_run = 0;
        m_el  = 0;
        m_cnt = 0;
        m_ovf = 0;
        m_udf = 0;
    endtask

    // One pclk: predict from pre-edge inputs, clock, then compare all outputs.
    task automatic cyc(input string ctx);
        bit t, so, su, nr, no, nu;
        int nc, ne;
        t  = m_tick();
        so = 0;
        su = 0;
        nc = m_cnt;
        if (bus.load) begin
            nc = int'(bus.tdr_data);
        end else if (t) begin
            if (!bus.cnt_dwn) begin
                so = (m_cnt == 255);
                nc = (m_cnt + 1) % 256;
            end else begin
                su = (m_cnt == 0);
                nc = (m_cnt + 255) % 256;
            end
        end
        no = so ? 1'b1 : (bus.ovf_clr ? 1'b0 : m_ovf);
        nu = su ? 1'b1 : (bus.udf_clr ? 1'b0 : m_udf);
        ne = (bus.load || !m_run || !bus.cnt_en) ? 0 : (m_el + 1) % 16;
        nr = bus.cnt_en;
        if (bus.load || t)
            $display("t=%0t %s load=%0b tdr=%02h step=%0b dwn=%0b sel=%0d -> tcnt=%02h ovf=%0b udf=%0b",
                     $time, ctx, bus.load, bus.tdr_data, t && !bus.load, bus.cnt_dwn, bus.clk_sel,
                     nc[7:0], no, nu);
        @(posedge pclk);
        #1;
        m_cnt = nc;
        m_ovf = no;
        m_udf = nu;
        m_el  = ne;
        m_run = nr;
        check_all(ctx);
    endtask

    task automatic pulse_load(input logic [7:0] val, input string ctx);
        bus.tdr_data = val;
        bus.load     = 1'b1;
        cyc(ctx);
        bus.load     = 1'b0;
    endtask

    task automatic wait_tick(input string ctx);
        int n;
        n = 0;
        while (!m_tick() && n < 40) begin
            cyc(ctx);
            n++;
        end
        check({ctx, ".wait"}, 32'(n < 40), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        bus.tdr_data = 8'h5A;
        bus.load     = 1'b1;
        bus.cnt_en   = 1'b0;
        bus.cnt_dwn  = 1'b0;
        bus.clk_sel  = 2'd0;
        bus.ovf_clr  = 1'b0;
        bus.udf_clr  = 1'b0;
        model_reset();

        // 1: reset holds everything at zero even with load asserted
        #1;
        check_all("t1_rst_a");
        @(posedge pclk);
        #1;
        check_all("t1_rst_b");
        #2;
        preset   = 1'b0;
        bus.load = 1'b0;
        pulse_load(8'h5A, "t1_load");
        check("t1_tcnt5a", 32'(bus.tcnt), 32'h5A);

        // 2: load never touches flags
        pulse_load(8'h00, "t2_ld00");
        pulse_load(8'hFF, "t2_ldff");
        check("t2_tcnt", 32'(bus.tcnt), 32'hFF);
        check("t2_udf",  32'(bus.udf_flag), 32'd0);
        check("t2_ovf",  32'(bus.ovf_flag), 32'd0);

        // 3: count up /2 through the FF->00 wrap
        bus.cnt_en = 1'b1;
        pulse_load(8'hFE, "t3_entry");
        cyc("t3"); cyc("t3");
        check("t3_ff", 32'(bus.tcnt), 32'hFF);
        cyc("t3"); cyc("t3");
        check("t3_00",  32'(bus.tcnt), 32'h00);
        check("t3_ovf", 32'(bus.ovf_flag), 32'd1);
        cyc("t3"); cyc("t3");
        check("t3_01", 32'(bus.tcnt), 32'h01);

        // 4: count down /16 through the 00->FF wrap, then clear udf
        bus.cnt_dwn = 1'b1;
        bus.clk_sel = 2'd3;
        bus.ovf_clr = 1'b1;
        pulse_load(8'h01, "t4_load");
        bus.ovf_clr = 1'b0;
        check("t4_ovfclr", 32'(bus.ovf_flag), 32'd0);
        repeat (16) cyc("t4");
        check("t4_00", 32'(bus.tcnt), 32'h00);
        repeat (16) cyc("t4");
        check("t4_ff",  32'(bus.tcnt), 32'hFF);
        check("t4_udf", 32'(bus.udf_flag), 32'd1);
        bus.udf_clr = 1'b1;
        cyc("t4_clr");
        bus.udf_clr = 1'b0;
        check("t4_udfclr", 32'(bus.udf_flag), 32'd0);

        // 5: set beats clear; load beats a coincident step
        bus.clk_sel = 2'd0;
        pulse_load(8'h00, "t5_ld00");
        wait_tick("t5_w1");
        bus.udf_clr = 1'b1;
        cyc("t5_setclr");
        bus.udf_clr = 1'b0;
        check("t5_udf", 32'(bus.udf_flag), 32'd1);
        check("t5_ff",  32'(bus.tcnt), 32'hFF);
        wait_tick("t5_w2");
        pulse_load(8'h80, "t5_ld80");
        check("t5_80", 32'(bus.tcnt), 32'h80);

        // 6: pause/resume at /4, then asynchronous reset mid-run
        bus.clk_sel = 2'd1;
        pulse_load(8'h10, "t6_load");
        repeat (8) cyc("t6_run");
        check("t6_0e", 32'(bus.tcnt), 32'h0E);
        bus.cnt_en = 1'b0;
        cyc("t6_exit");
        saved = m_cnt;
        for (int i = 0; i < 8; i++) begin
            cyc("t6_idle");
            check("t6_frozen", 32'(bus.tcnt), 32'(saved));
        end
        bus.cnt_en = 1'b1;
        cyc("t6_entry");
        repeat (3) cyc("t6_resume");
        check("t6_hold", 32'(bus.tcnt), 32'(saved));
        cyc("t6_step");
        check("t6_dec", 32'(bus.tcnt), 32'((saved + 255) % 256));
        repeat (5) cyc("t6_run2");
        @(posedge pclk);
        #3;
        preset = 1'b1;
        #1;
        model_reset();
        check_all("t6_rst");
        #2;
        preset = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 700; i++) begin
            int pick;
            pick = $urandom_range(0, 4);
            case (pick)
                0: bus.tdr_data = 8'h00;
                1: bus.tdr_data = 8'h01;
                2: bus.tdr_data = 8'hFE;
                3: bus.tdr_data = 8'hFF;
                default: bus.tdr_data = 8'($urandom);
            endcase
            bus.load    = ($urandom_range(0, 15) == 0);
            bus.cnt_en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) bus.cnt_dwn = ~bus.cnt_dwn;
            if ($urandom_range(0, 29) == 0) bus.clk_sel = 2'($urandom);
            bus.ovf_clr = ($urandom_range(0, 7) == 0);
            bus.udf_clr = ($urandom_range(0, 7) == 0);
            cyc("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/timer_cnt_core.md
Name: timer_cnt_core

Overview:
- Counting engine of the APB timer; sits directly downstream of the timer register block.
- Consumes TDR data, the TCR load/enable/direction/clock-select fields and TSR flag-clear strobes.
- Produces the live TCNT value and the sticky TSR overflow (bit0) and underflow (bit1) flags read back over APB.
- Contains the PCLK prescaler, the run/idle control FSM, the 8-bit up/down counter and the flag logic.

Parameters:
CNT_WIDTH, 8, width of TDR/TCNT
DIV_WIDTH, 4, prescaler counter width; the maximum divide ratio is 2**DIV_WIDTH

Ports:
pclk  input  1  APB clock; the only clock
preset  input  1  asynchronous active-high reset
tdr_data  input  CNT_WIDTH  current TDR value
load  input  1  single-cycle pulse on a TCR write with bit7=1
cnt_en  input  1  TCR[4]; count enable, level
cnt_dwn  input  1  TCR[5]; 1 = count down, 0 = count up
clk_sel  input  2  TCR[1:0]; 00=/2, 01=/4, 10=/8, 11=/16
ovf_clr  input  1  single-cycle pulse; clears ovf_flag
udf_clr  input  1  single-cycle pulse; clears udf_flag
tcnt  output  CNT_WIDTH  current counter value
ovf_flag  output  1  sticky overflow flag (TSR[0])
udf_flag  output  1  sticky underflow flag (TSR[1])
tick  output  1  prescaler step pulse, for observation

Behaviour:
- Reset (asynchronous, active-high): tcnt=0, ovf_flag=0, udf_flag=0, tick=0, div_cnt=0, FSM in IDLE.
- FSM has two states:
  - IDLE: div_cnt held at 0 and tick=0. Moves to RUN at the first clock edge where cnt_en=1.
  - RUN: div_cnt increments every pclk and wraps. Moves to IDLE at the first clock edge where cnt_en=0. Entering IDLE does not change tcnt.
- Prescaler:
  - tick is combinational from registered state.
  - tick=1 in RUN when the low (clk_sel+1) bits of div_cnt are all ones. This gives exactly one tick every 2,4,8,16 pclk.
  - The first tick after entering RUN comes 2^(clk_sel+1) cycles after the entry edge.
  - A clk_sel change takes effect on the next cycle. div_cnt is not cleared by the change.
- Counter step (on a pclk edge with RUN and tick=1 and load=0):
  - Up: tcnt+1. From tcnt=FF the result is 00 and ovf_flag is set.
  - Down: tcnt-1. From tcnt=00 the result is FF and udf_flag is set.
  - Arithmetic is modulo 2**CNT_WIDTH.
- Load:
  - On a load edge, tcnt <= tdr_data and div_cnt <= 0 in the same edge.
  - Load has priority over a coincident step; that step is discarded.
  - Load never sets or clears either flag, so writing TDR=00, loading, then TDR=FF and loading leaves udf_flag=0.
  - Load is accepted in both IDLE and RUN.
- Flags:
  - Sticky until the corresponding clr pulse; the cleared flag reads 0 from the following cycle.
  - Set and clr in the same cycle: set wins, flag stays 1.
  - ovf and udf are independent; both may be 1 at once after a direction change.
- Direction change while in RUN: applies to the next step; no extra step and no flag.
- cnt_en and load in the same cycle: the load executes and the FSM enters RUN. The first step comes a full divide period after the load.
- Reset asserted mid-count: immediate return to the reset values; no step completes.
- Latency:
  - tcnt updates one pclk after the load edge or tick edge.
  - A flag is visible in the same cycle as the wrapped tcnt value.

Test Plan:
1. Reset with tdr_data=5A, load=1 -> all outputs 0. Deassert reset, then pulse load -> tcnt=5A next cycle, flags 0.
2. Load 00, then load FF, cnt_en=0 -> tcnt=FF, udf_flag=0, ovf_flag=0.
3. Load FE, cnt_dwn=0, clk_sel=00, cnt_en=1 -> tcnt=FF at 2 pclk after entry, 00 at 4 pclk with ovf_flag=1, 01 at 6 pclk.
4. Load 01, cnt_dwn=1, clk_sel=11, cnt_en=1 -> tcnt=00 after 16 pclk, FF after 32 pclk with udf_flag=1. Pulse udf_clr -> udf_flag=0.
5. udf_clr pulsed in the same cycle as an underflow step -> udf_flag remains 1. Load 80 coincident with a tick -> tcnt=80, no decrement.
6. Counting down at clk_sel=01 from 10: drop cnt_en for 8 pclk then restore -> tcnt frozen while IDLE, first resumed step 4 pclk after re-entry. Assert preset mid-run -> tcnt=0, flags 0 immediately.
